// File: rtl/quote_order_gen_if.sv
// Quote-in / order-out signal bundle for quote_order_gen.
// The trading pipeline and the exchange-side encoder connect through the master modport.
interface quote_order_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4
);
  localparam int ID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic [DATA_WIDTH-1:0] i_buy_price;
  logic [DATA_WIDTH-1:0] i_sell_price;
  logic [ID_W-1:0]       i_stock_id;
  logic                  i_data_valid;
  logic                  i_flush;
  logic                  o_order_valid;
  logic                  i_order_ready;
  logic                  o_order_side;
  logic [ID_W-1:0]       o_order_stock_id;
  logic [DATA_WIDTH-1:0] o_order_price;
  logic                  o_overflow;
  logic [15:0]           o_drop_count;

  modport master (
    output i_buy_price, i_sell_price, i_stock_id, i_data_valid, i_flush, i_order_ready,
    input  o_order_valid, o_order_side, o_order_stock_id, o_order_price, o_overflow, o_drop_count
  );

  modport slave (
    input  i_buy_price, i_sell_price, i_stock_id, i_data_valid, i_flush, i_order_ready,
    output o_order_valid, o_order_side, o_order_stock_id, o_order_price, o_overflow, o_drop_count
  );
endinterface

// File: rtl/quote_order_gen.sv
// Quote-to-order generator: keeps the last quote sent per stock and emits buy/sell orders
// only for new or moved quotes, through a first-word fall-through FIFO with registered head.
module quote_order_gen #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          NUM_STOCKS      = 4,
  parameter int          FIFO_DEPTH      = 8,
  parameter int unsigned PRICE_THRESHOLD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  quote_order_gen_if.slave   bus
);
  localparam int ID_W  = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DW1   = DATA_WIDTH + 1;

  typedef struct packed {
    logic                  side;
    logic [ID_W-1:0]       stock;
    logic [DATA_WIDTH-1:0] price;
  } entry_t;

  entry_t                mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] last_buy_r  [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_sell_r [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] tbl_valid_r;
  entry_t                head_r;
  logic                  head_valid_r;
  logic                  overflow_r;
  logic [15:0]           drop_count_r;

  logic [ID_W-1:0]       id_s;
  logic                  send_buy_s;
  logic                  send_sell_s;
  logic [1:0]            need_s;
  logic [1:0]            push_n_s;
  logic                  pop_s;
  logic                  live_s;
  logic                  accept_s;
  logic                  drop_s;
  logic [CNT_W:0]        room_s;
  logic [CNT_W-1:0]      remain_s;
  logic [CNT_W-1:0]      cnt_next_s;
  logic [PTR_W-1:0]      rd_ptr_n_s;
  entry_t                e0_s;
  entry_t                e1_s;
  entry_t                head_n_s;

  // Unsigned distance in DATA_WIDTH+1 bits so the subtraction can never wrap.
  function automatic logic moved(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [DW1-1:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d > DW1'(PRICE_THRESHOLD);
  endfunction

  // Side decision, room check and next FIFO head.
  always_comb begin
    id_s        = bus.i_stock_id;
    send_buy_s  = !tbl_valid_r[id_s] || moved(bus.i_buy_price, last_buy_r[id_s]);
    send_sell_s = !tbl_valid_r[id_s] || moved(bus.i_sell_price, last_sell_r[id_s]);
    need_s      = {1'b0, send_buy_s} + {1'b0, send_sell_s};
    pop_s       = head_valid_r && bus.i_order_ready;
    room_s      = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, count_r} + (CNT_W+1)'(pop_s);
    live_s      = bus.i_data_valid && !bus.i_flush;
    accept_s    = live_s && (need_s != 2'd0) && ((CNT_W+1)'(need_s) <= room_s);
    drop_s      = live_s && ((CNT_W+1)'(need_s) > room_s);
    push_n_s    = accept_s ? need_s : 2'd0;
    e0_s        = send_buy_s ? {1'b0, id_s, bus.i_buy_price} : {1'b1, id_s, bus.i_sell_price};
    e1_s        = {1'b1, id_s, bus.i_sell_price};
    remain_s    = count_r - CNT_W'(pop_s);
    cnt_next_s  = remain_s + CNT_W'(push_n_s);
    rd_ptr_n_s  = rd_ptr_r + PTR_W'(pop_s);
    // Once the FIFO drains, the first entry written this cycle becomes the head.
    if (remain_s != {CNT_W{1'b0}}) begin
      head_n_s = mem_r[rd_ptr_n_s];
    end else if (push_n_s != 2'd0) begin
      head_n_s = e0_s;
    end else begin
      head_n_s = '0;
    end
  end

  // Order storage; buy lands before sell so it is read out first.
  always_ff @(posedge i_clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= e0_s;
      if (need_s == 2'd2) begin
        mem_r[wr_ptr_r + PTR_W'(1)] <= e1_s;
      end
    end
  end

  // FIFO pointers, last-quote table, registered head and drop accounting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      tbl_valid_r  <= '0;
      head_r       <= '0;
      head_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      drop_count_r <= 16'h0000;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        last_buy_r[s]  <= '0;
        last_sell_r[s] <= '0;
      end
    end else if (bus.i_flush) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      tbl_valid_r  <= '0;
      head_r       <= '0;
      head_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      wr_ptr_r     <= wr_ptr_r + PTR_W'(push_n_s);
      rd_ptr_r     <= rd_ptr_n_s;
      count_r      <= cnt_next_s;
      head_r       <= head_n_s;
      head_valid_r <= (cnt_next_s != {CNT_W{1'b0}});
      overflow_r   <= drop_s;
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
      if (accept_s) begin
        if (send_buy_s) begin
          last_buy_r[id_s] <= bus.i_buy_price;
        end else begin
          last_buy_r[id_s] <= last_buy_r[id_s];
        end
        if (send_sell_s) begin
          last_sell_r[id_s] <= bus.i_sell_price;
        end else begin
          last_sell_r[id_s] <= last_sell_r[id_s];
        end
        tbl_valid_r[id_s] <= 1'b1;
      end else begin
        tbl_valid_r <= tbl_valid_r;
      end
    end
  end

  assign bus.o_order_valid    = head_valid_r;
  assign bus.o_order_side     = head_r.side;
  assign bus.o_order_stock_id = head_r.stock;
  assign bus.o_order_price    = head_r.price;
  assign bus.o_overflow       = overflow_r;
  assign bus.o_drop_count     = drop_count_r;
endmodule

// File: tb/tb_quote_order_gen.sv
// Bench for quote_order_gen: two instances (threshold 0 and 2) share one stimulus stream
// and are checked every cycle against a queue-based model, plus hand-computed expectations.
module tb_quote_order_gen;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic          side;
    logic [1:0]    stock;
    logic [DW-1:0] price;
  } order_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] buy = '0, sell = '0;
  logic [1:0]    sid = '0;
  logic          dv = 1'b0, flush = 1'b0, ready = 1'b0;

  int vectors = 0;
  int errors  = 0;

  quote_order_gen_if #(.DATA_WIDTH(DW), .NUM_STOCKS(NS)) if_a ();
  quote_order_gen_if #(.DATA_WIDTH(DW), .NUM_STOCKS(NS)) if_b ();

  assign if_a.i_buy_price   = buy;
  assign if_a.i_sell_price  = sell;
  assign if_a.i_stock_id    = sid;
  assign if_a.i_data_valid  = dv;
  assign if_a.i_flush       = flush;
  assign if_a.i_order_ready = ready;
  assign if_b.i_buy_price   = buy;
  assign if_b.i_sell_price  = sell;
  assign if_b.i_stock_id    = sid;
  assign if_b.i_data_valid  = dv;
  assign if_b.i_flush       = flush;
  assign if_b.i_order_ready = ready;

  quote_order_gen #(.DATA_WIDTH(DW), .NUM_STOCKS(NS), .FIFO_DEPTH(DEPTH), .PRICE_THRESHOLD(0))
    dut_t0 (.i_clk(clk), .i_reset(rst), .bus(if_a));
  quote_order_gen #(.DATA_WIDTH(DW), .NUM_STOCKS(NS), .FIFO_DEPTH(DEPTH), .PRICE_THRESHOLD(2))
    dut_t2 (.i_clk(clk), .i_reset(rst), .bus(if_b));

  logic [1:0]    o_valid, o_side, o_ovf;
  logic [1:0]    o_stock [2];
  logic [DW-1:0] o_price [2];
  logic [15:0]   o_drops [2];
  assign o_valid[0] = if_a.o_order_valid;    assign o_valid[1] = if_b.o_order_valid;
  assign o_side[0]  = if_a.o_order_side;     assign o_side[1]  = if_b.o_order_side;
  assign o_ovf[0]   = if_a.o_overflow;       assign o_ovf[1]   = if_b.o_overflow;
  assign o_stock[0] = if_a.o_order_stock_id; assign o_stock[1] = if_b.o_order_stock_id;
  assign o_price[0] = if_a.o_order_price;    assign o_price[1] = if_b.o_order_price;
  assign o_drops[0] = if_a.o_drop_count;     assign o_drops[1] = if_b.o_drop_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance pending-order queue and last-sent table.
  order_t        mq [2][$];
  logic [DW-1:0] m_lb [2][NS];
  logic [DW-1:0] m_ls [2][NS];
  bit            m_vld [2][NS];
  int            m_drops [2];
  bit            m_ovf [2];

  function automatic bit moved(input longint a, input longint b, input longint t);
    return ((a > b) ? (a - b) : (b - a)) > t;
  endfunction

  initial begin : model
    bit sb, ss;
    int need;
    longint thr;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        thr = (k == 0) ? 0 : 2;
        if (rst) begin
          mq[k].delete();
          for (int s = 0; s < NS; s++) m_vld[k][s] = 1'b0;
          m_drops[k] = 0;
          m_ovf[k] = 1'b0;
        end else if (flush) begin
          mq[k].delete();
          for (int s = 0; s < NS; s++) m_vld[k][s] = 1'b0;
          m_ovf[k] = 1'b0;
        end else begin
          if (mq[k].size() > 0 && ready) void'(mq[k].pop_front());
          m_ovf[k] = 1'b0;
          if (dv) begin
            sb = !m_vld[k][sid] || moved(longint'(buy), longint'(m_lb[k][sid]), thr);
            ss = !m_vld[k][sid] || moved(longint'(sell), longint'(m_ls[k][sid]), thr);
            need = int'(sb) + int'(ss);
            if (need > DEPTH - mq[k].size()) begin
              m_ovf[k] = 1'b1;
              if (m_drops[k] < 65535) m_drops[k]++;
            end else begin
              if (sb) begin
                mq[k].push_back({1'b0, sid, buy});
                m_lb[k][sid] = buy;
              end
              if (ss) begin
                mq[k].push_back({1'b1, sid, sell});
                m_ls[k][sid] = sell;
              end
              if (need > 0) m_vld[k][sid] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model, away from the clock edge.
  initial begin : compare
    order_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("model_valid[%0d]", k), 64'(o_valid[k]), 64'(mq[k].size() != 0));
          if (mq[k].size() != 0) begin
            h = mq[k][0];
            chk($sformatf("model_side[%0d]", k), 64'(o_side[k]), 64'(h.side));
            chk($sformatf("model_stock[%0d]", k), 64'(o_stock[k]), 64'(h.stock));
            chk($sformatf("model_price[%0d]", k), 64'(o_price[k]), 64'(h.price));
          end
          chk($sformatf("model_ovf[%0d]", k), 64'(o_ovf[k]), 64'(m_ovf[k]));
          chk($sformatf("model_drops[%0d]", k), 64'(o_drops[k]), 64'(m_drops[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quote(input logic [1:0] id, input logic [DW-1:0] b, input logic [DW-1:0] s);
    sid = id; buy = b; sell = s; dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin : stim
    int nq;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 64'(o_valid[k]), 64'd0);
      chk("rst_side", 64'(o_side[k]), 64'd0);
      chk("rst_stock", 64'(o_stock[k]), 64'd0);
      chk("rst_price", 64'(o_price[k]), 64'd0);
      chk("rst_ovf", 64'(o_ovf[k]), 64'd0);
      chk("rst_drops", 64'(o_drops[k]), 64'd0);
    end
    rst = 1'b0;
    tick();

    // New quote: buy then sell, valid one edge after acceptance.
    quote(2'd1, 32'd100, 32'd105);
    chk("t1_valid", 64'(o_valid[0]), 64'd1);
    chk("t1_side", 64'(o_side[0]), 64'd0);
    chk("t1_stock", 64'(o_stock[0]), 64'd1);
    chk("t1_price", 64'(o_price[0]), 64'd100);
    chk("t1_ovf", 64'(o_ovf[0]), 64'd0);
    ready = 1'b1;
    tick();
    chk("t1_sell_side", 64'(o_side[0]), 64'd1);
    chk("t1_sell_price", 64'(o_price[0]), 64'd105);
    tick();
    chk("t1_empty", 64'(o_valid[0]), 64'd0);
    ready = 1'b0;

    // Sell moved by 1: one order at threshold 0, none at threshold 2.
    quote(2'd1, 32'd100, 32'd106);
    chk("t2_valid_thr0", 64'(o_valid[0]), 64'd1);
    chk("t2_side_thr0", 64'(o_side[0]), 64'd1);
    chk("t2_price_thr0", 64'(o_price[0]), 64'd106);
    chk("t2_valid_thr2", 64'(o_valid[1]), 64'd0);
    ready = 1'b1;
    tick();
    chk("t2_single", 64'(o_valid[0]), 64'd0);
    ready = 1'b0;

    // Fill to 8, then a two-order quote must be dropped whole.
    do_flush();
    for (int i = 0; i < 4; i++) quote(2'(i), DW'(200 + i), DW'(300 + i));
    quote(2'd0, 32'd50, 32'd60);
    chk("t3_ovf", 64'(o_ovf[0]), 64'd1);
    chk("t3_drops", 64'(o_drops[0]), 64'd1);
    chk("t3_drops_thr2", 64'(o_drops[1]), 64'd1);
    chk("t3_head", 64'(o_price[0]), 64'd200);
    tick();
    chk("t3_ovf_pulse", 64'(o_ovf[0]), 64'd0);
    ready = 1'b1;
    repeat (8) tick();
    ready = 1'b0;
    chk("t3_drained", 64'(o_valid[0]), 64'd0);
    quote(2'd0, 32'd50, 32'd60);
    chk("t3_resend_buy", 64'(o_price[0]), 64'd50);
    ready = 1'b1;
    tick();
    chk("t3_resend_sell", 64'(o_price[0]), 64'd60);
    tick();
    ready = 1'b0;

    // Seven entries plus a same-cycle pop leaves room for two.
    do_flush();
    quote(2'd0, 32'd10, 32'd20);
    quote(2'd1, 32'd11, 32'd21);
    quote(2'd2, 32'd12, 32'd22);
    quote(2'd0, 32'd15, 32'd20);
    ready = 1'b1;
    quote(2'd3, 32'd13, 32'd23);
    ready = 1'b0;
    chk("t4_accept_ovf", 64'(o_ovf[0]), 64'd0);
    chk("t4_accept_drops", 64'(o_drops[0]), 64'd1);
    quote(2'd1, 32'd99, 32'd21);
    chk("t4_full_ovf", 64'(o_ovf[0]), 64'd1);
    chk("t4_full_drops", 64'(o_drops[0]), 64'd2);
    ready = 1'b1;
    repeat (9) tick();
    ready = 1'b0;

    // Flush wins over a same-cycle quote and keeps the drop count.
    do_flush();
    quote(2'd0, 32'd1, 32'd2);
    quote(2'd0, 32'd5, 32'd2);
    flush = 1'b1;
    sid = 2'd2; buy = 32'd7; sell = 32'd8; dv = 1'b1;
    tick();
    flush = 1'b0; dv = 1'b0;
    chk("t5_flushed", 64'(o_valid[0]), 64'd0);
    chk("t5_drops", 64'(o_drops[0]), 64'd2);
    chk("t5_ovf", 64'(o_ovf[0]), 64'd0);
    quote(2'd2, 32'd7, 32'd8);
    chk("t5_requote_valid", 64'(o_valid[0]), 64'd1);
    chk("t5_requote_price", 64'(o_price[0]), 64'd7);
    ready = 1'b1;
    tick(); tick();
    ready = 1'b0;

    // Randomized traffic with backpressure, occasional flush and one mid-stream reset.
    nq = 0;
    while (nq < 1000) begin
      ready = 1'($urandom_range(0, 1));
      if (nq == 500) begin
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_valid[0]), 64'd0);
        chk("mid_rst_drops", 64'(o_drops[1]), 64'd0);
        tick();
        rst = 1'b0;
        nq++;
      end else if ($urandom_range(0, 63) == 0) begin
        do_flush();
      end else if ($urandom_range(0, 3) != 0) begin
        quote(2'($urandom_range(0, NS - 1)), DW'(1000 + $urandom_range(0, 6)),
              DW'(2000 + $urandom_range(0, 6)));
        nq++;
      end else begin
        tick();
      end
    end
    ready = 1'b1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/quote_order_gen.md
Name: quote_order_gen

Overview:
- Sits directly downstream of the trading-logic pipeline.
- Consumes per-stock buy/sell quote prices and keeps a table of the last quote sent for each stock.
- Emits buy/sell order messages only when a quote is new or has moved by more than a threshold.
- Messages are buffered in a FIFO and drained through a valid/ready stream toward the exchange-side encoder.

Parameters:
- DATA_WIDTH, 32, price width in bits.
- NUM_STOCKS, 4, number of tracked stocks; stock id width is $clog2(NUM_STOCKS).
- FIFO_DEPTH, 8, order FIFO entries; power of two, minimum 2.
- PRICE_THRESHOLD, 0, minimum absolute price change that triggers a re-quote; 0 means any change.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_buy_price  in  DATA_WIDTH  new bid quote.
- i_sell_price  in  DATA_WIDTH  new ask quote.
- i_stock_id  in  $clog2(NUM_STOCKS)  stock the quote belongs to.
- i_data_valid  in  1  quote valid; single-cycle pulse, no backpressure to upstream.
- i_flush  in  1  clear FIFO and last-quote table.
- o_order_valid  out  1  FIFO head valid.
- i_order_ready  in  1  downstream accepts head.
- o_order_side  out  1  0 = buy, 1 = sell.
- o_order_stock_id  out  $clog2(NUM_STOCKS)  stock of head order.
- o_order_price  out  DATA_WIDTH  price of head order.
- o_overflow  out  1  one-cycle pulse when an update is dropped.
- o_drop_count  out  16  saturating count of dropped updates.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty, all table entries invalid.
  - o_order_valid=0, o_order_side=0, o_order_stock_id=0, o_order_price=0, o_overflow=0, o_drop_count=0.
- Table: per stock, last_buy, last_sell (DATA_WIDTH) and one valid bit.
- Side decision, evaluated on each i_data_valid cycle:
  - send_buy = !valid[id] || |i_buy_price - last_buy[id]| > PRICE_THRESHOLD.
  - send_sell is computed the same way using i_sell_price and last_sell[id].
  - Absolute difference is computed unsigned in DATA_WIDTH+1 bits; no wrap.
- need = send_buy + send_sell (0, 1 or 2).
- Room check uses FIFO free slots after this cycle's pop, i.e. free + (o_order_valid && i_order_ready).
- If need ≤ room:
  - Push the needed entries; buy is written before sell, so buy is read out first.
  - Update last_* only for the sides sent.
  - Set valid[id]=1.
- If need > room:
  - Push nothing and leave the table unchanged.
  - Pulse o_overflow=1 for one cycle.
  - o_drop_count increments, saturating at 16'hFFFF.
  - Partial pushes are never allowed.
- need = 0: no push, no table change, no overflow.
- FIFO behaviour:
  - First-word fall-through; supports 2 writes and 1 read per cycle.
  - Count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Latency: a quote accepted at edge N with the FIFO empty gives o_order_valid=1 with the buy entry after edge N.
- Output stream:
  - Head pops on any cycle where o_order_valid && i_order_ready.
  - Head fields stay stable while o_order_valid=1 && !i_order_ready.
  - o_order_valid never drops without a pop, except on flush or reset.
- i_flush (synchronous):
  - Next edge: FIFO empty, all valid bits cleared.
  - Takes priority over a same-cycle i_data_valid, which is discarded without counting as an overflow.
  - o_drop_count is retained.
- Same-stock updates on consecutive cycles: the second update compares against the table as written by the first (no stale read).
- Reset asserted mid-stream discards FIFO contents immediately.

Test Plan:
- Reset, then stock 1 quote buy=100, sell=105 → order (buy,1,100) with valid after 1 edge, then (sell,1,105); o_overflow=0.
- Repeat stock 1 quote buy=100, sell=106 with PRICE_THRESHOLD=0 → exactly one order (sell,1,106); with PRICE_THRESHOLD=2 → no order.
- i_order_ready=0, DEPTH=8, four distinct-stock quotes followed by a fifth on stock 0 → FIFO holds 8 entries; fifth update dropped, o_overflow pulses, o_drop_count=1; stock 0 table unchanged, so resending it after drain yields 2 orders.
- FIFO at 7 entries with i_order_ready=1 and a 2-order quote in the same cycle → accepted (room counts the pop); count stays 8.
- i_flush together with i_data_valid while FIFO holds 3 entries → next cycle o_order_valid=0, o_drop_count unchanged; the following identical quote produces 2 orders.
- Backpressure toggled randomly over 1000 quotes on all stocks → output order sequence matches a reference model; no field changes while stalled; pointer wrap exercised.
